hazard_control_unit: RTL and testbench

Pipeline hazard sequencer for the 5-stage MIPS core. It works alongside the forwarding unit and covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, and freezing the pipeline while the multi-cycle multiply/divide unit (MDU) runs. It sits beside the ID/EX register and drives the PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls.

---
 rtl/hazard_control_unit.sv | 128 ++++++++++++
 tb/tb_hazard_control_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Hazard sequencer for the 5-stage core: load-use stalls, taken-branch flushes, MDU freeze.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_W       = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] IFID_src1,
    input  logic [REG_W-1:0] IFID_src2,
    input  logic             IFID_uses_src2,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_dest,
    input  logic             IDEX_mdu_start,
    input  logic             EX_branch_taken,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_bubble,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam int unsigned     CNT_W    = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             frozen;

    always_comb begin
        lu = IDEX_MemRead && (IDEX_dest != '0) &&
             ((IDEX_dest == IFID_src1) || (IFID_uses_src2 && (IDEX_dest == IFID_src2)));
        frozen = (state_q == MDU_BUSY) && (cnt_q != '0);

        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEX_write   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        EXMEM_bubble = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;

        if (frozen) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_bubble = 1'b1;
            mdu_busy     = 1'b1;
            cnt_d        = cnt_q - CNT_W'(1);
        end else begin
            // Final MDU cycle resolves hazards exactly like RUN, plus the done pulse.
            if (state_q == MDU_BUSY) begin
                mdu_done = 1'b1;
                mdu_busy = 1'b1;
                state_d  = RUN;
            end
            if (EX_branch_taken) begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
            end else if (lu) begin
                PC_write   = 1'b0;
                IFID_write = 1'b0;
                IDEX_flush = 1'b1;
            end
            if (IDEX_mdu_start && !EX_branch_taken) begin
                cnt_d   = CNT_LOAD;
                state_d = MDU_BUSY;
            end
        end

        if (!reset_n) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            IFID_flush   = 1'b0;
            IDEX_flush   = 1'b0;
            EXMEM_bubble = 1'b0;
            mdu_busy     = 1'b0;
            mdu_done     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!PC_write) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (IFID_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: per-cycle expected control vectors queued and compared.
module tb_hazard_control_unit;

    logic        clk;
    logic        reset_n;
    logic [4:0]  IFID_src1, IFID_src2, IDEX_dest;
    logic        IFID_uses_src2, IDEX_MemRead, IDEX_mdu_start, EX_branch_taken;
    logic        PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush;
    logic        EXMEM_bubble, mdu_busy, mdu_done;
    logic [31:0] stall_cnt, flush_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    // {PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush, EXMEM_bubble, mdu_busy, mdu_done}
    localparam logic [7:0] V_RST  = 8'b0000_0000;
    localparam logic [7:0] V_OK   = 8'b1110_0000;
    localparam logic [7:0] V_LU   = 8'b0010_1000;
    localparam logic [7:0] V_BR   = 8'b1111_1000;
    localparam logic [7:0] V_BUSY = 8'b0000_0110;
    localparam logic [7:0] V_DONE = 8'b1110_0011;
    localparam logic [7:0] V_DLU  = 8'b0010_1011;

    hazard_control_unit #(
        .MDU_LATENCY(4),
        .REG_W      (5)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .IFID_src1      (IFID_src1),
        .IFID_src2      (IFID_src2),
        .IFID_uses_src2 (IFID_uses_src2),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_dest      (IDEX_dest),
        .IDEX_mdu_start (IDEX_mdu_start),
        .EX_branch_taken(EX_branch_taken),
        .PC_write       (PC_write),
        .IFID_write     (IFID_write),
        .IDEX_write     (IDEX_write),
        .IFID_flush     (IFID_flush),
        .IDEX_flush     (IDEX_flush),
        .EXMEM_bubble   (EXMEM_bubble),
        .mdu_busy       (mdu_busy),
        .mdu_done       (mdu_done),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected controls, compare mid-cycle.
    task automatic cyc(input string tag, input logic rn, input logic mr, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic u2,
                       input logic ms, input logic br, input logic [7:0] exp);
        sb_item_t it;
        reset_n         = rn;
        IDEX_MemRead    = mr;
        IDEX_dest       = d;
        IFID_src1       = s1;
        IFID_src2       = s2;
        IFID_uses_src2  = u2;
        IDEX_mdu_start  = ms;
        EX_branch_taken = br;
        sb_q.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        it = sb_q.pop_front();
        check_eq(it.tag, 32'({PC_write, IFID_write, IDEX_write, IFID_flush, IDEX_flush,
                              EXMEM_bubble, mdu_busy, mdu_done}), 32'(it.exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [7:0] exp);
        cyc(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic mdu_start(input string tag, input logic [7:0] exp);
        cyc(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, exp);
    endtask

    task automatic reset_cycle(input string tag);
        cyc(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST);
    endtask

    initial begin
        reset_n = 1'b0; IDEX_MemRead = 1'b0; IDEX_dest = '0; IFID_src1 = '0; IFID_src2 = '0;
        IFID_uses_src2 = 1'b0; IDEX_mdu_start = 1'b0; EX_branch_taken = 1'b0;
        @(posedge clk);
        #1;

        reset_cycle("reset0");
        reset_cycle("reset1");
        check_eq("cnt_reset_stall", stall_cnt, 32'd0);
        check_eq("cnt_reset_flush", flush_cnt, 32'd0);
        idle("idle", V_OK);

        cyc("lu_src1", 1'b1, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, V_LU);
        idle("lu_release", V_OK);
        cyc("lu_dest0", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, V_OK);
        cyc("lu_src2_unused", 1'b1, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, V_OK);
        cyc("lu_src2_used", 1'b1, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, V_LU);
        cyc("lu_noload", 1'b1, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, V_OK);
        cyc("branch_over_lu", 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, V_BR);
        idle("post_branch", V_OK);

        mdu_start("mdu_c0", V_OK);
        idle("mdu_c1", V_BUSY);
        cyc("mdu_c2_branch", 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, V_BUSY);
        idle("mdu_c3", V_BUSY);
        idle("mdu_c4_done", V_DONE);
        idle("mdu_c5_run", V_OK);

        mdu_start("b2b_c0", V_OK);
        for (int unsigned i = 0; i < 3; i++) idle("b2b_busy_a", V_BUSY);
        mdu_start("b2b_done_restart", V_DONE);
        for (int unsigned i = 0; i < 3; i++) idle("b2b_busy_b", V_BUSY);
        cyc("b2b_done_lu", 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, V_DLU);
        idle("b2b_run", V_OK);

        mdu_start("rstmdu_c0", V_OK);
        idle("rstmdu_c1", V_BUSY);
        reset_cycle("rstmdu_c2_reset");
        idle("rstmdu_c3_run", V_OK);
        idle("rstmdu_c4_nodone", V_OK);
        idle("rstmdu_c5_nodone", V_OK);

        reset_cycle("perf_reset");
        cyc("perf_lu", 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, V_LU);
        idle("perf_idle0", V_OK);
        mdu_start("perf_mdu_c0", V_OK);
        for (int unsigned i = 0; i < 3; i++) idle("perf_mdu_busy", V_BUSY);
        idle("perf_mdu_done", V_DONE);
        cyc("perf_br0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, V_BR);
        idle("perf_idle1", V_OK);
        cyc("perf_br1", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, V_BR);
        idle("perf_idle2", V_OK);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("perf_stall_cnt", stall_cnt, 32'd4);
        check_eq("perf_flush_cnt", flush_cnt, 32'd2);
`else
        check_eq("perf_stall_cnt", stall_cnt, 32'd0);
        check_eq("perf_flush_cnt", flush_cnt, 32'd0);
`endif

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
